// File: rtl/uart_cmd_rcv_if.sv
// Command-receiver bus: serial line in, consumer acknowledge in, decoded byte and status out.
// Latency: none, this is wiring only.
// Backpressure: cmd_rdy is held until the consumer pulses clr_cmd_rdy.
interface uart_cmd_rcv_if;
  logic       RX;
  logic       clr_cmd_rdy;
  logic [7:0] cmd;
  logic       cmd_rdy;
  logic       frm_err;
  logic       overrun;

  // Line driver / command consumer side
  modport master (
    output RX,
    output clr_cmd_rdy,
    input  cmd,
    input  cmd_rdy,
    input  frm_err,
    input  overrun
  );

  // Receiver side
  modport slave (
    input  RX,
    input  clr_cmd_rdy,
    output cmd,
    output cmd_rdy,
    output frm_err,
    output overrun
  );
endinterface

// File: rtl/uart_cmd_rcv.sv
// UART 8N1 command receiver: synchronizes RX, frames one byte, holds it in cmd with a cmd_rdy level.
// Latency: RX falling edge to cmd_rdy = 3 + BAUD_DIV/2 + 9*BAUD_DIV cycles; stop sample to cmd_rdy = 1 cycle.
// Backpressure: none on the line; a byte landing while cmd_rdy is still set overwrites cmd and pulses overrun.
module uart_cmd_rcv #(
  parameter int BAUD_DIV = 2604
) (
  input  logic           clk,
  input  logic           rst,
  uart_cmd_rcv_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // 16 bits hold the largest legal divisor, so the baud counter never wraps inside a bit.
  localparam logic [15:0] FULL_CNT = 16'(BAUD_DIV);
  localparam logic [15:0] HALF_CNT = 16'(BAUD_DIV / 2);

  logic        rx_meta;
  logic        rx_sync;
  logic [1:0]  sync_fill;   // marks when rx_sync holds a genuine line sample after reset
  logic        armed;       // line has been seen high in IDLE; next low is a real falling edge
  state_t      state;
  logic [15:0] baud_cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [7:0]  cmd_q;
  logic        cmd_rdy_q;
  logic        frm_err_q;
  logic        overrun_q;
  logic        expire;

  // A bit period ends on the cycle the counter reaches 1, giving exactly the loaded count in cycles.
  assign expire = (baud_cnt <= 16'd1);

  // Two-flop synchronizer on RX; the fill shift tells IDLE when the reset value has been flushed out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      sync_fill <= 2'b00;
    end else begin
      rx_meta   <= bus.RX;
      rx_sync   <= rx_meta;
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

  // Receive state machine with registered outputs; clr_cmd_rdy only touches cmd_rdy, and a landing byte wins over it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      armed     <= 1'b0;
      baud_cnt  <= 16'd0;
      bit_cnt   <= 4'd0;
      shreg     <= 8'h00;
      cmd_q     <= 8'h00;
      cmd_rdy_q <= 1'b0;
      frm_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      frm_err_q <= 1'b0;
      overrun_q <= 1'b0;
      if (bus.clr_cmd_rdy) begin
        cmd_rdy_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          // Only real samples count: a low line at reset release or after a framing error must go high first.
          if (sync_fill[1]) begin
            if (rx_sync) begin
              armed <= 1'b1;
            end else if (armed) begin
              armed    <= 1'b0;
              state    <= START;
              baud_cnt <= HALF_CNT;
              bit_cnt  <= 4'd0;
            end
          end
        end

        START: begin
          if (expire) begin
            if (rx_sync) begin
              state    <= IDLE;
              baud_cnt <= 16'd0;
            end else begin
              state    <= DATA;
              baud_cnt <= FULL_CNT;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end

        DATA: begin
          if (expire) begin
            shreg    <= {rx_sync, shreg[7:1]};
            bit_cnt  <= bit_cnt + 4'd1;
            baud_cnt <= FULL_CNT;
            if (bit_cnt == 4'd7) begin
              state <= STOP;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end

        STOP: begin
          if (expire) begin
            state    <= IDLE;
            baud_cnt <= 16'd0;
            if (rx_sync) begin
              cmd_q     <= shreg;
              cmd_rdy_q <= 1'b1;
              overrun_q <= cmd_rdy_q & ~bus.clr_cmd_rdy;
            end else begin
              frm_err_q <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end

        default: begin
          state    <= IDLE;
          baud_cnt <= 16'd0;
        end
      endcase
    end
  end

  assign bus.cmd     = cmd_q;
  assign bus.cmd_rdy = cmd_rdy_q;
  assign bus.frm_err = frm_err_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_uart_cmd_rcv.sv
// Bench for uart_cmd_rcv: directed frames plus random frames, checked through an event scoreboard.
// Latency: expected event time is fall edge + 3 + B/2 + 9*B, accepted within one cycle.
// Backpressure: consumer clears are issued by the bench; overrun expectations follow the consumer model.
module tb_uart_cmd_rcv;
  localparam int B   = 16;
  localparam int LAT = 2 + 1 + B / 2 + 9 * B;

  typedef struct {
    bit         ferr;
    logic [7:0] data;
    bit         ovr;
    bit         rdy;
    int         t;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  exp_t       sb[$];
  bit         model_rdy;
  logic [7:0] model_cmd;

  uart_cmd_rcv_if bus();

  uart_cmd_rcv #(.BAUD_DIV(B)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_time(input string name, input int act, input int exp);
    n_cmp++;
    if (act < exp - 1 || act > exp + 1) begin
      n_bad++;
      $display("FAIL %s: event at cycle %0d expected %0d +/-1", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one full frame; the expected outcome is queued before the start bit goes out.
  task automatic send_frame(input logic [7:0] d, input bit stop, input bit coinc, input bit hold_low);
    exp_t       e;
    logic [9:0] bits;
    bits   = {stop, d, 1'b0};
    e.ferr = !stop;
    e.ovr  = stop && model_rdy && !coinc;
    if (stop) begin
      model_rdy = 1'b1;
      model_cmd = d;
    end
    e.data = model_cmd;
    e.rdy  = model_rdy;
    @(posedge clk);
    #1;
    bus.RX = 1'b0;
    e.t = cyc + LAT;
    sb.push_back(e);
    for (int c = 1; c < 10 * B; c++) begin
      @(posedge clk);
      #1;
      bus.RX          = bits[c / B];
      bus.clr_cmd_rdy = coinc && (c == LAT - 1);
    end
    @(posedge clk);
    #1;
    bus.clr_cmd_rdy = 1'b0;
    bus.RX = hold_low ? 1'b0 : 1'b1;
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1;
    bus.clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1;
    bus.clr_cmd_rdy = 1'b0;
    model_rdy = 1'b0;
    check("clr_rdy", {31'd0, bus.cmd_rdy}, 32'd0);
    check("clr_cmd_hold", {24'd0, bus.cmd}, {24'd0, model_cmd});
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_cmd"}, {24'd0, bus.cmd}, 32'd0);
    check({tag, "_rdy"}, {31'd0, bus.cmd_rdy}, 32'd0);
    check({tag, "_ferr"}, {31'd0, bus.frm_err}, 32'd0);
    check({tag, "_ovr"}, {31'd0, bus.overrun}, 32'd0);
  endtask

  // Monitor: every frm_err pulse or landed byte must match the oldest queued expectation.
  initial begin
    exp_t       e;
    logic       land;
    logic       p_rdy;
    logic       p_ferr;
    logic       p_ovr;
    logic [7:0] p_cmd;
    p_rdy  = 1'b0;
    p_ferr = 1'b0;
    p_ovr  = 1'b0;
    p_cmd  = 8'h00;
    forever begin
      @(negedge clk);
      land = (bus.cmd_rdy && !p_rdy) || bus.overrun || (bus.cmd_rdy && bus.cmd != p_cmd);
      if (!rst && (bus.frm_err || land)) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: cmd=%0h rdy=%0b ferr=%0b ovr=%0b at cycle %0d, expected none",
                   bus.cmd, bus.cmd_rdy, bus.frm_err, bus.overrun, cyc);
        end else begin
          e = sb.pop_front();
          check("event_kind_ferr", {31'd0, bus.frm_err}, {31'd0, e.ferr});
          check("event_cmd", {24'd0, bus.cmd}, {24'd0, e.data});
          check("event_rdy", {31'd0, bus.cmd_rdy}, {31'd0, e.rdy});
          check("event_ovr", {31'd0, bus.overrun}, {31'd0, e.ovr});
          check_time("event_time", cyc, e.t);
          if (bus.frm_err) check("ferr_width", {31'd0, p_ferr}, 32'd0);
          if (bus.overrun) check("ovr_width", {31'd0, p_ovr}, 32'd0);
        end
      end
      p_rdy  = bus.cmd_rdy;
      p_ferr = bus.frm_err;
      p_ovr  = bus.overrun;
      p_cmd  = bus.cmd;
    end
  end

  initial begin
    logic [7:0] d;
    bit         stop;
    bit         coinc;
    model_rdy       = 1'b0;
    model_cmd       = 8'h00;
    rst             = 1'b1;
    bus.RX          = 1'b1;
    bus.clr_cmd_rdy = 1'b0;
    idle(3);
    check_zero("reset");
    rst = 1'b0;
    idle(10);
    check_zero("post_reset");

    // Basic frame, then consumer acknowledge
    send_frame(8'h73, 1'b1, 1'b0, 1'b0);
    idle(20);
    check("cmd_73", {24'd0, bus.cmd}, 32'h73);
    check("rdy_73", {31'd0, bus.cmd_rdy}, 32'd1);
    pulse_clr();

    // Framing error, line then held low: no new frame may start
    send_frame(8'h49, 1'b0, 1'b0, 1'b1);
    idle(80);
    bus.RX = 1'b1;
    idle(30);
    check("cmd_after_ferr", {24'd0, bus.cmd}, 32'h73);
    check("rdy_after_ferr", {31'd0, bus.cmd_rdy}, 32'd0);

    // Overrun, then set-wins against a coincident clear
    send_frame(8'h5F, 1'b1, 1'b0, 1'b0);
    idle(10);
    send_frame(8'h1F, 1'b1, 1'b0, 1'b0);
    idle(10);
    check("cmd_1f", {24'd0, bus.cmd}, 32'h1F);
    send_frame(8'h3A, 1'b1, 1'b1, 1'b0);
    idle(10);
    check("rdy_coinc", {31'd0, bus.cmd_rdy}, 32'd1);
    check("cmd_3a", {24'd0, bus.cmd}, 32'h3A);

    // Short low glitch is a false start
    @(posedge clk);
    #1;
    bus.RX = 1'b0;
    idle(4);
    bus.RX = 1'b1;
    idle(40);
    check("glitch_cmd", {24'd0, bus.cmd}, {24'd0, model_cmd});
    check("glitch_rdy", {31'd0, bus.cmd_rdy}, {31'd0, model_rdy});
    check("glitch_ferr", {31'd0, bus.frm_err}, 32'd0);

    // Reset in the middle of data bit 4 of 0xD7, released with the line low
    begin
      logic [9:0] bits;
      bits = {1'b1, 8'hD7, 1'b0};
      @(posedge clk);
      #1;
      bus.RX = 1'b0;
      for (int c = 1; c < 5 * B + B / 2; c++) begin
        @(posedge clk);
        #1;
        bus.RX = bits[c / B];
      end
    end
    #3;
    rst = 1'b1;
    #1;
    check_zero("mid_reset");
    model_rdy = 1'b0;
    model_cmd = 8'h00;
    idle(3);
    bus.RX = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(40);
    check_zero("low_release");
    bus.RX = 1'b1;
    idle(20);
    send_frame(8'h2D, 1'b1, 1'b0, 1'b0);
    idle(10);
    check("cmd_2d", {24'd0, bus.cmd}, 32'h2D);
    check("rdy_2d", {31'd0, bus.cmd_rdy}, 32'd1);

    // Random frames against the consumer model
    for (int i = 0; i < 30; i++) begin
      if (model_rdy && $urandom_range(0, 9) < 6) pulse_clr();
      d     = 8'($urandom);
      stop  = ($urandom_range(0, 9) != 0);
      coinc = stop && model_rdy && (d != model_cmd) && ($urandom_range(0, 3) == 0);
      send_frame(d, stop, coinc, 1'b0);
      idle($urandom_range(1, 30));
      check("rand_cmd", {24'd0, bus.cmd}, {24'd0, model_cmd});
      check("rand_rdy", {31'd0, bus.cmd_rdy}, {31'd0, model_rdy});
    end

    idle(200);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_cmd_rcv.md
UART_CMD_RCV -- requirements
Module: uart_cmd_rcv

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be asynchronous and active-high.
REQ-002 Parameter: BAUD_DIV, default 2604, clocks per bit (50 MHz / 19200 baud); legal values 8..65535.
REQ-003 Port: clk  input  1  system clock; all state on rising edge.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: RX  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 Port: clr_cmd_rdy  input  1  consumer acknowledge; clears cmd_rdy.
REQ-007 Port: cmd  output  8  last correctly framed byte.
REQ-008 Port: cmd_rdy  output  1  level; new cmd available, held until cleared.
REQ-009 Port: frm_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-010 Port: overrun  output  1  one-cycle pulse; byte landed while cmd_rdy still set.

Function
REQ-011 RX SHALL pass through a two-flop synchronizer whose flops reset to 1; all logic uses the synchronized value only.
REQ-012 States SHALL be IDLE, START, DATA, STOP.
REQ-013 IDLE: a synchronized 1->0 transition SHALL move to START and load the baud counter with BAUD_DIV/2 (integer divide).
REQ-014 START: on counter expiry, RX sampled 1 SHALL be a false start -> IDLE with no output change; sampled 0 -> DATA, counter reloaded with BAUD_DIV.
REQ-015 DATA: on each expiry one bit SHALL shift into an 8-bit register from the MSB end (LSB received first); after the 8th bit -> STOP, counter reloaded with BAUD_DIV.
REQ-016 A 4-bit bit counter SHALL track data bits; it resets to 0 on entering START.
REQ-017 STOP, sample 1: cmd SHALL load the shift register and cmd_rdy SHALL be 1 from the next cycle; state -> IDLE.
REQ-018 STOP, sample 0: frm_err SHALL pulse for exactly one cycle, cmd and cmd_rdy unchanged; state -> IDLE.
REQ-019 After a framing error, IDLE SHALL require RX to be sampled high before accepting a new falling edge (no re-trigger on a held-low line).
REQ-020 clr_cmd_rdy SHALL clear cmd_rdy on the next edge; cmd SHALL hold its value.
REQ-021 If a byte completes in the same cycle clr_cmd_rdy is asserted, set SHALL win: cmd_rdy stays 1 with the new byte, and overrun SHALL NOT pulse.
REQ-022 If a byte completes while cmd_rdy=1 and clr_cmd_rdy=0, cmd SHALL be overwritten, cmd_rdy stays 1 and overrun SHALL pulse one cycle.
REQ-023 Stop-bit sample to cmd_rdy rise SHALL be 1 cycle; RX falling edge to cmd_rdy rise SHALL equal 2 + 1 + BAUD_DIV/2 + 9*BAUD_DIV cycles (+/-1).
REQ-024 Bit-count and baud-counter widths SHALL not wrap within a frame for any legal BAUD_DIV.
REQ-025 clr_cmd_rdy SHALL have no effect on the receive state machine.

Reset
REQ-026 On rst, asynchronously: state=IDLE, cmd=0x00, cmd_rdy=0, frm_err=0, overrun=0, counters=0, synchronizer=1, shift register=0x00.
REQ-027 rst asserted mid-frame SHALL abort the frame; after release the block SHALL wait for RX high, then a fresh falling edge.
REQ-028 An RX low present at reset release SHALL NOT start a frame.

Verification (BAUD_DIV=16)
REQ-029 Send 0x73 with a valid stop bit -> cmd=0x73, cmd_rdy=1 about 155 cycles after the start edge; frm_err=0, overrun=0.
REQ-030 With cmd_rdy=1, pulse clr_cmd_rdy for one cycle -> cmd_rdy=0 next cycle; cmd still 0x73.
REQ-031 Send 0x49, stop bit driven 0 -> one-cycle frm_err; cmd stays 0x73, cmd_rdy stays 0; line held low causes no new frame.
REQ-032 Send 0x5F, then 0x1F without clearing -> cmd=0x1F, cmd_rdy=1, one overrun pulse; repeat with clr_cmd_rdy coincident with the completion -> cmd_rdy=1, no overrun.
REQ-033 Low glitch of 4 cycles on idle RX -> false start; no change to cmd, cmd_rdy or frm_err.
REQ-034 Assert rst during bit 4 of 0xD7 -> all outputs 0 immediately; next full 0x2D frame -> cmd=0x2D, cmd_rdy=1.
